equiv_stim_gen: RTL and testbench

EQUIV_STIM_GEN -- requirements
Module: equiv_stim_gen

---
 rtl/equiv_stim_gen.sv | 144 ++++++++++++++
 tb/tb_equiv_stim_gen.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/equiv_stim_gen.sv
// Pattern FIFO plus playback FSM that drives a stimulus pair for equivalence checking.
// Optional error injection on signal_1 is enabled by defining EQUIV_GEN_ERR_INJ_EN.
module equiv_stim_gen #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
`ifdef EQUIV_GEN_ERR_INJ_EN
  input  logic             inj_err,
`endif
  input  logic             pat_valid,
  input  logic [1:0]       pat_data,
  output logic             pat_ready,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             signal_0,
  output logic             signal_1,
  output logic             exp_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;

  logic [1:0]       mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  state_e           state_q;
  logic [HoldW-1:0] hold_q;
  logic             sig0_q, sig1_q, exp_q;
  logic [CNT_W-1:0] pass_q, fail_q;

  logic       full, empty, push, pop;
  logic [1:0] head;
  logic       load_sig1;

  assign full      = (count_q == CntW'(DEPTH));
  assign empty     = (count_q == '0);
  assign pat_ready = !full && !rst;
  assign push      = pat_valid && pat_ready;
  assign head      = mem_q[rd_ptr_q];

`ifdef EQUIV_GEN_ERR_INJ_EN
  assign load_sig1 = head[0] ^ inj_err;
`else
  assign load_sig1 = head[0];
`endif

  // A pop happens only on a pattern-load edge: start from idle, or end of hold in play.
  always_comb begin
    pop = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle:  pop = start && !empty;
        StPlay:  pop = (hold_q == '0) && !empty;
        default: pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pat_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hold_q  <= '0;
      sig0_q  <= 1'b0;
      sig1_q  <= 1'b0;
      exp_q   <= 1'b0;
      pass_q  <= '0;
      fail_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_q <= StPlay;
            sig0_q  <= head[1];
            sig1_q  <= load_sig1;
            exp_q   <= (head[1] == head[0]);
            hold_q  <= HoldW'(HOLD_CYCLES - 1);
            pass_q  <= '0;
            fail_q  <= '0;
          end
        end
        StPlay: begin
          // Count the relation actually driven this cycle, saturating.
          if (sig0_q == sig1_q) begin
            if (pass_q != '1) pass_q <= pass_q + CNT_W'(1);
          end else begin
            if (fail_q != '1) fail_q <= fail_q + CNT_W'(1);
          end
          if (hold_q != '0) begin
            hold_q <= hold_q - HoldW'(1);
          end else if (pop) begin
            sig0_q <= head[1];
            sig1_q <= load_sig1;
            exp_q  <= (head[1] == head[0]);
            hold_q <= HoldW'(HOLD_CYCLES - 1);
          end else begin
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = (state_q == StPlay);
  assign done     = (state_q == StDone);
  assign signal_0 = sig0_q;
  assign signal_1 = sig1_q;
  assign exp_pass = exp_q;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;

endmodule

// File: tb/tb_equiv_stim_gen.sv
// Directed bench for equiv_stim_gen: two instances (HOLD 1 / HOLD 3 with 2-bit counters)
// share stimulus and are checked every cycle against a queue-based playback model.
module tb_equiv_stim_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pat_valid = 1'b0;
  logic [1:0] pat_data = 2'b00;
  logic       start = 1'b0;
`ifdef EQUIV_GEN_ERR_INJ_EN
  logic       inj_err = 1'b0;
`endif

  logic        d1_ready, d1_busy, d1_done, d1_s0, d1_s1, d1_ep;
  logic [15:0] d1_pc, d1_fc;
  logic        d3_ready, d3_busy, d3_done, d3_s0, d3_s1, d3_ep;
  logic [1:0]  d3_pc, d3_fc;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  equiv_stim_gen #(.DEPTH(4), .HOLD_CYCLES(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst),
`ifdef EQUIV_GEN_ERR_INJ_EN
    .inj_err(inj_err),
`endif
    .pat_valid(pat_valid), .pat_data(pat_data), .pat_ready(d1_ready),
    .start(start), .busy(d1_busy), .done(d1_done),
    .signal_0(d1_s0), .signal_1(d1_s1), .exp_pass(d1_ep),
    .pass_cnt(d1_pc), .fail_cnt(d1_fc)
  );

  equiv_stim_gen #(.DEPTH(4), .HOLD_CYCLES(3), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst(rst),
`ifdef EQUIV_GEN_ERR_INJ_EN
    .inj_err(inj_err),
`endif
    .pat_valid(pat_valid), .pat_data(pat_data), .pat_ready(d3_ready),
    .start(start), .busy(d3_busy), .done(d3_done),
    .signal_0(d3_s0), .signal_1(d3_s1), .exp_pass(d3_ep),
    .pass_cnt(d3_pc), .fail_cnt(d3_fc)
  );

  // Model: phase 0 idle, 1 playing, 2 done; rem = cycles left on the current pattern.
  int         hold_of [2] = '{1, 3};
  int         cmax [2]    = '{65535, 3};
  logic [1:0] m_q [2][8];
  int         m_n [2];
  int         m_phase [2];
  int         m_rem [2];
  int         m_pc [2];
  int         m_fc [2];
  logic       m_s0 [2];
  logic       m_s1 [2];
  logic       m_ep [2];

  logic [3:0] e_s0 = 4'b1010;
  logic [3:0] e_s1 = 4'b1100;
  logic [3:0] e_ep = 4'b1001;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear(input int k);
    m_n[k] = 0; m_phase[k] = 0; m_rem[k] = 0; m_pc[k] = 0; m_fc[k] = 0;
    m_s0[k] = 1'b0; m_s1[k] = 1'b0; m_ep[k] = 1'b0;
  endtask

  task automatic model_load(input int k, input logic inj);
    logic [1:0] p;
    p = m_q[k][0];
    for (int j = 0; j < 7; j++) m_q[k][j] = m_q[k][j+1];
    m_n[k]--;
    m_s0[k]  = p[1];
    m_s1[k]  = p[0] ^ inj;
    m_ep[k]  = (p[1] == p[0]);
    m_rem[k] = hold_of[k];
  endtask

  task automatic model_step();
    logic inj_eff;
    bit   do_push;
`ifdef EQUIV_GEN_ERR_INJ_EN
    inj_eff = inj_err;
`else
    inj_eff = 1'b0;
`endif
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        model_clear(k);
      end else begin
        do_push = pat_valid && (m_n[k] < 4);
        case (m_phase[k])
          0: if (start && m_n[k] > 0) begin
            model_load(k, inj_eff);
            m_pc[k] = 0;
            m_fc[k] = 0;
            m_phase[k] = 1;
          end
          1: begin
            if (m_s0[k] == m_s1[k]) begin
              if (m_pc[k] < cmax[k]) m_pc[k]++;
            end else begin
              if (m_fc[k] < cmax[k]) m_fc[k]++;
            end
            m_rem[k]--;
            if (m_rem[k] == 0) begin
              if (m_n[k] > 0) model_load(k, inj_eff);
              else m_phase[k] = 2;
            end
          end
          default: m_phase[k] = 0;
        endcase
        if (do_push) begin
          m_q[k][m_n[k]] = pat_data;
          m_n[k]++;
        end
      end
    end
  endtask

  task automatic cmp(input int k, input logic ready, input logic busy, input logic done,
                     input logic s0, input logic s1, input logic ep, input int pc, input int fc);
    chk($sformatf("dut%0d.pat_ready", k), int'(ready), int'((m_n[k] < 4) && !rst));
    chk($sformatf("dut%0d.busy", k), int'(busy), int'(m_phase[k] == 1));
    chk($sformatf("dut%0d.done", k), int'(done), int'(m_phase[k] == 2));
    chk($sformatf("dut%0d.signal_0", k), int'(s0), int'(m_s0[k]));
    chk($sformatf("dut%0d.signal_1", k), int'(s1), int'(m_s1[k]));
    chk($sformatf("dut%0d.exp_pass", k), int'(ep), int'(m_ep[k]));
    chk($sformatf("dut%0d.pass_cnt", k), pc, m_pc[k]);
    chk($sformatf("dut%0d.fail_cnt", k), fc, m_fc[k]);
  endtask

  // One clock: model follows the edge, both DUTs are compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp(0, d1_ready, d1_busy, d1_done, d1_s0, d1_s1, d1_ep, int'(d1_pc), int'(d1_fc));
    cmp(1, d3_ready, d3_busy, d3_done, d3_s0, d3_s1, d3_ep, int'(d3_pc), int'(d3_fc));
  endtask

  task automatic push(input logic [1:0] p);
    pat_valid = 1'b1;
    pat_data  = p;
    cycle();
    pat_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((d1_busy || d1_done || d3_busy || d3_done) && g < 100) begin
      cycle();
      g++;
    end
    chk("idle_timeout", int'(g < 100), 1);
  endtask

  initial begin
    model_clear(0);
    model_clear(1);
    cycle();
    cycle();
    chk("rst_ready", int'(d1_ready), 0);
    chk("rst_busy", int'(d1_busy), 0);
    chk("rst_pass_cnt", int'(d1_pc), 0);
    rst = 1'b0;
    cycle();
    chk("ready_after_rst", int'(d1_ready), 1);

    // Four-pattern sequence, one cycle each on dut1; dut3 counters saturate at 3.
    push(2'b00); push(2'b10); push(2'b01); push(2'b11);
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("seq%0d_s0", i), int'(d1_s0), int'(e_s0[i]));
      chk($sformatf("seq%0d_s1", i), int'(d1_s1), int'(e_s1[i]));
      chk($sformatf("seq%0d_exp", i), int'(d1_ep), int'(e_ep[i]));
      chk($sformatf("seq%0d_busy", i), int'(d1_busy), 1);
      cycle();
    end
    chk("seq_done", int'(d1_done), 1);
    chk("seq_pass", int'(d1_pc), 2);
    chk("seq_fail", int'(d1_fc), 2);
    wait_idle();
    chk("sat_pass", int'(d3_pc), 3);
    chk("sat_fail", int'(d3_fc), 3);

    // Full FIFO drops the fifth push.
    push(2'b01); push(2'b01); push(2'b10); push(2'b10);
    chk("full_ready", int'(d1_ready), 0);
    push(2'b00);
    start = 1'b1; cycle(); start = 1'b0;
    chk("ready_after_pop", int'(d1_ready), 1);
    wait_idle();
    chk("full_fail", int'(d1_fc), 4);
    chk("full_pass", int'(d1_pc), 0);

    // Start with empty FIFO is ignored.
    start = 1'b1; cycle(); start = 1'b0;
    chk("empty_busy", int'(d1_busy), 0);
    chk("empty_done", int'(d1_done), 0);
    chk("empty_hold_s0", int'(d1_s0), 1);
    chk("empty_hold_fail", int'(d1_fc), 4);
    cycle();
    chk("empty_done2", int'(d1_done), 0);

    // Single pattern held three cycles on dut3.
    push(2'b10);
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold%0d_busy", i), int'(d3_busy), 1);
      chk($sformatf("hold%0d_s0", i), int'(d3_s0), 1);
      chk($sformatf("hold%0d_s1", i), int'(d3_s1), 0);
      cycle();
    end
    chk("hold_done", int'(d3_done), 1);
    chk("hold_fail", int'(d3_fc), 3);
    chk("hold_pass", int'(d3_pc), 0);
    wait_idle();

    // Push on the start edge: simultaneous push/pop, second pattern follows with no gap.
    push(2'b10);
    start = 1'b1; pat_valid = 1'b1; pat_data = 2'b11;
    cycle();
    start = 1'b0; pat_valid = 1'b0;
    chk("contig0_s0", int'(d1_s0), 1);
    chk("contig0_s1", int'(d1_s1), 0);
    cycle();
    chk("contig1_busy", int'(d1_busy), 1);
    chk("contig1_s1", int'(d1_s1), 1);
    chk("contig1_exp", int'(d1_ep), 1);
    cycle();
    chk("contig_done", int'(d1_done), 1);
    chk("contig_pass", int'(d1_pc), 1);
    chk("contig_fail", int'(d1_fc), 1);
    wait_idle();

    // Reset in the second play cycle aborts and flushes.
    push(2'b00); push(2'b01); push(2'b10); push(2'b11);
    start = 1'b1; cycle(); start = 1'b0;
    cycle();
    rst = 1'b1; cycle();
    chk("abort_busy", int'(d1_busy), 0);
    chk("abort_s1", int'(d1_s1), 0);
    chk("abort_pass", int'(d1_pc), 0);
    chk("abort_ready", int'(d1_ready), 0);
    rst = 1'b0; cycle();
    chk("abort_ready_after", int'(d1_ready), 1);
    chk("abort_no_done", int'(d1_done), 0);
    start = 1'b1; cycle(); start = 1'b0;
    chk("abort_flushed", int'(d1_busy), 0);
    push(2'b01);
    start = 1'b1; cycle(); start = 1'b0;
    chk("replay_busy", int'(d1_busy), 1);
    chk("replay_s1", int'(d1_s1), 1);
    chk("replay_exp", int'(d1_ep), 0);
    wait_idle();
    chk("replay_fail", int'(d1_fc), 1);

`ifdef EQUIV_GEN_ERR_INJ_EN
    push(2'b11);
    start = 1'b1; inj_err = 1'b1; cycle(); start = 1'b0; inj_err = 1'b0;
    chk("inj_s0", int'(d1_s0), 1);
    chk("inj_s1", int'(d1_s1), 0);
    chk("inj_exp", int'(d1_ep), 1);
    wait_idle();
    chk("inj_fail", int'(d1_fc), 1);
    chk("inj_pass", int'(d1_pc), 0);
    chk("inj_fail3", int'(d3_fc), 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
